mbist_march_ctrl: RTL and testbench

- Parametrised memory BIST controller: on `start`, runs a selectable march algorithm over a single-port synchronous SRAM and reports pass/fail.
- Successor to the fixed-algorithm BIST top. Adds:
  - algorithm select (MATS+ / March C-)
  - programmable data background
  - first-fail address/data capture
  - saturating fail counter
  - optional stop-on-first-fail
- Sits between the test controller (`start`/`done`) and the memory under test.

---
 rtl/mbist_pkg.sv | 56 +++++
 rtl/mbist_march_ctrl_if.sv | 14 +
 rtl/mbist_cmp.sv | 63 ++++++
 rtl/mbist_march_ctrl.sv | 136 +++++++++++++
 tb/tb_mbist_march_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mbist_pkg.sv
// Shared types and march element tables for the memory BIST controller.
package mbist_pkg;

    localparam logic [1:0] MODE_MATS   = 2'b00;
    localparam logic [1:0] MODE_MARCHC = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    // pol=0 uses the latched background D, pol=1 uses ~D
    typedef struct packed {
        logic wr;
        logic pol;
    } op_t;

    typedef struct packed {
        logic down;
        logic has2;
        op_t  op1;
        op_t  op2;
    } elem_t;

    localparam op_t W0 = '{wr: 1'b1, pol: 1'b0};
    localparam op_t W1 = '{wr: 1'b1, pol: 1'b1};
    localparam op_t R0 = '{wr: 1'b0, pol: 1'b0};
    localparam op_t R1 = '{wr: 1'b0, pol: 1'b1};

    localparam logic [2:0] MATS_ELEMS   = 3'd3;
    localparam logic [2:0] MARCHC_ELEMS = 3'd6;

    function automatic logic [2:0] elem_count(input logic [1:0] mode);
        return (mode == MODE_MARCHC) ? MARCHC_ELEMS : MATS_ELEMS;
    endfunction

    function automatic elem_t get_elem(input logic [1:0] mode, input logic [2:0] idx);
        elem_t e;
        e = '{down: 1'b0, has2: 1'b0, op1: W0, op2: W0};
        if (mode == MODE_MARCHC) begin
            case (idx)
                3'd1:    e = '{down: 1'b0, has2: 1'b1, op1: R0, op2: W1};
                3'd2:    e = '{down: 1'b0, has2: 1'b1, op1: R1, op2: W0};
                3'd3:    e = '{down: 1'b1, has2: 1'b1, op1: R0, op2: W1};
                3'd4:    e = '{down: 1'b1, has2: 1'b1, op1: R1, op2: W0};
                3'd5:    e = '{down: 1'b0, has2: 1'b0, op1: R0, op2: W0};
                default: e = '{down: 1'b0, has2: 1'b0, op1: W0, op2: W0};
            endcase
        end else begin
            case (idx)
                3'd1:    e = '{down: 1'b0, has2: 1'b1, op1: R0, op2: W1};
                3'd2:    e = '{down: 1'b1, has2: 1'b1, op1: R1, op2: W0};
                default: e = '{down: 1'b0, has2: 1'b0, op1: W0, op2: W0};
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Single-port synchronous SRAM bus; read data returns the cycle after mem_re.
interface mbist_march_ctrl_if #(
    parameter int data_width = 4,
    parameter int ad_width   = 4
);
    logic [ad_width-1:0]   mem_addr;
    logic [data_width-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [data_width-1:0] mem_rdata;

    modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/mbist_cmp.sv
// Read-data checker: registers each read's address/expected value, compares on return.
// Latency: compare one cycle after the read is issued; flags update on the following edge.
// Backpressure: none; mismatch is combinational so the sequencer can stop in the same cycle.
module mbist_cmp #(
    parameter int data_width = 4,
    parameter int ad_width   = 4,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  set_inv,
    input  logic                  rd_issue,
    input  logic [ad_width-1:0]   rd_addr,
    input  logic [data_width-1:0] rd_exp,
    input  logic [data_width-1:0] rdata,
    output logic                  mismatch,
    output logic                  fail,
    output logic [ad_width-1:0]   fail_addr,
    output logic [data_width-1:0] fail_data,
    output logic [cnt_width-1:0]  fail_count
);
    localparam logic [cnt_width-1:0] CNT_ONE = 1;

    logic                  rd_pend;
    logic [data_width-1:0] exp_q;
    logic [ad_width-1:0]   addr_q;

    assign mismatch = rd_pend && (rdata != exp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            exp_q      <= '0;
            addr_q     <= '0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            fail_count <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) begin
                exp_q  <= rd_exp;
                addr_q <= rd_addr;
            end
            if (clr) begin
                fail       <= set_inv;
                fail_addr  <= '0;
                fail_data  <= '0;
                fail_count <= '0;
            end else if (mismatch) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= addr_q;
                    fail_data <= rdata ^ exp_q;
                end
                if (fail_count != '1)
                    fail_count <= fail_count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March BIST sequencer: walks the selected element table, one memory op per cycle.
// Latency: first op the cycle after start; done L+2 cycles after the start edge.
// Backpressure: none; start is ignored while busy, a mismatch can abort when stop_on_fail=1.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int data_width   = 4,
    parameter int ad_width     = 4,
    parameter int cnt_width    = 8,
    parameter bit stop_on_fail = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [data_width-1:0] bg,
    mbist_march_ctrl_if.master    mem,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ad_width-1:0]   fail_addr,
    output logic [data_width-1:0] fail_data,
    output logic [cnt_width-1:0]  fail_count
);
    localparam logic [ad_width-1:0] ADDR_ONE = 1;

    state_e                state, state_nx;
    logic [1:0]            mode_r, mode_nx;
    logic [data_width-1:0] bg_r, bg_nx;
    logic [2:0]            elem, elem_nx;
    logic [ad_width-1:0]   addr, addr_nx;
    logic                  phase, phase_nx;

    elem_t                 cur;
    op_t                   op;
    logic [data_width-1:0] dat;
    logic                  issue, stop_now, last_addr, last_op;
    logic                  clr, set_inv, mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_r <= '0;
            bg_r   <= '0;
            elem   <= '0;
            addr   <= '0;
            phase  <= 1'b0;
        end else begin
            state  <= state_nx;
            mode_r <= mode_nx;
            bg_r   <= bg_nx;
            elem   <= elem_nx;
            addr   <= addr_nx;
            phase  <= phase_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mode_nx   = mode_r;
        bg_nx     = bg_r;
        elem_nx   = elem;
        addr_nx   = addr;
        phase_nx  = phase;
        clr       = 1'b0;
        set_inv   = 1'b0;
        cur       = get_elem(mode_r, elem);
        op        = phase ? cur.op2 : cur.op1;
        dat       = op.pol ? ~bg_r : bg_r;
        stop_now  = stop_on_fail && mismatch;
        issue     = (state == S_RUN) && !stop_now;
        last_addr = cur.down ? (addr == '0) : (addr == '1);
        last_op   = (!cur.has2 || phase) && last_addr
                    && (elem == elem_count(mode_r) - 3'd1);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clr      = 1'b1;
                    mode_nx  = mode;
                    bg_nx    = bg;
                    elem_nx  = '0;
                    addr_nx  = '0;
                    phase_nx = 1'b0;
                    set_inv  = mode[1];
                    state_nx = mode[1] ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (stop_now || last_op) begin
                    state_nx = S_DRAIN;
                end else if (cur.has2 && !phase) begin
                    phase_nx = 1'b1;
                end else begin
                    phase_nx = 1'b0;
                    if (last_addr) begin
                        // each element restarts at the end its own direction requires
                        elem_nx = elem + 3'd1;
                        addr_nx = get_elem(mode_r, elem + 3'd1).down ? '1 : '0;
                    end else begin
                        addr_nx = cur.down ? addr - ADDR_ONE : addr + ADDR_ONE;
                    end
                end
            end
            S_DRAIN: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign mem.mem_addr  = addr;
    assign mem.mem_we    = issue & op.wr;
    assign mem.mem_re    = issue & ~op.wr;
    assign mem.mem_wdata = issue ? dat : '0;
    assign busy          = (state == S_RUN) || (state == S_DRAIN);
    assign done          = (state == S_DONE);

    mbist_cmp #(
        .data_width (data_width),
        .ad_width   (ad_width),
        .cnt_width  (cnt_width)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .set_inv    (set_inv),
        .rd_issue   (mem.mem_re),
        .rd_addr    (addr),
        .rd_exp     (dat),
        .rdata      (mem.mem_rdata),
        .mismatch   (mismatch),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .fail_count (fail_count)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench: two controllers (stop_on_fail 0 and 1) each on a memory model with injectable stuck-at bits.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [3:0] bg;

    always #5 clk = ~clk;

    mbist_march_ctrl_if #(.data_width(4), .ad_width(4)) bus0 ();
    mbist_march_ctrl_if #(.data_width(4), .ad_width(4)) bus1 ();

    logic       busy0, done0, fail0, busy1, done1, fail1;
    logic [3:0] fa0, fd0, fa1, fd1;
    logic [7:0] fc0, fc1;

    mbist_march_ctrl #(.data_width(4), .ad_width(4), .cnt_width(8), .stop_on_fail(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bg(bg), .mem(bus0),
        .busy(busy0), .done(done0), .fail(fail0), .fail_addr(fa0), .fail_data(fd0), .fail_count(fc0)
    );

    mbist_march_ctrl #(.data_width(4), .ad_width(4), .cnt_width(8), .stop_on_fail(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bg(bg), .mem(bus1),
        .busy(busy1), .done(done1), .fail(fail1), .fail_addr(fa1), .fail_data(fd1), .fail_count(fc1)
    );

    logic [3:0] mem0 [16];
    logic [3:0] mem1 [16];
    logic [3:0] stuck [16];

    always @(posedge clk) begin
        if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
        if (bus0.mem_re) bus0.mem_rdata <= mem0[bus0.mem_addr] | stuck[bus0.mem_addr];
        if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
        if (bus1.mem_re) bus1.mem_rdata <= mem1[bus1.mem_addr] | stuck[bus1.mem_addr];
    end

    int   checks = 0;
    int   passes = 0;
    int   cyc, ops0, ops1, done0_cyc, done1_cyc;
    logic fail0_c1, done0_c1, busy0_c1;

    // cyc=1 is the cycle right after the start edge; runs are bounded to 400 cycles
    task automatic run(input logic [1:0] m, input logic [3:0] b, input bit glitch);
        @(negedge clk);
        start = 1'b1; mode = m; bg = b;
        @(posedge clk); #1;
        start = 1'b0;
        ops0 = 0; ops1 = 0; done0_cyc = 0; done1_cyc = 0; cyc = 1;
        fail0_c1 = fail0; done0_c1 = done0; busy0_c1 = busy0;
        while (cyc <= 400) begin
            if (bus0.mem_we || bus0.mem_re) ops0++;
            if (bus1.mem_we || bus1.mem_re) ops1++;
            if (done0 && done0_cyc == 0) done0_cyc = cyc;
            if (done1 && done1_cyc == 0) done1_cyc = cyc;
            if (done0_cyc != 0 && done1_cyc != 0) break;
            if (glitch && cyc == 20) begin
                start = 1'b1; mode = 2'b10;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'b00; bg = 4'h0;
        for (int i = 0; i < 16; i++) stuck[i] = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({busy0, done0, fail0} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy0, done0, fail0}); else passes++;
        checks++; if ({fc0, fa0, fd0} !== 16'h0) $display("FAIL reset_fail_regs: got %h expected 0000", {fc0, fa0, fd0}); else passes++;
        checks++; if ({bus0.mem_we, bus0.mem_re, bus0.mem_addr, bus0.mem_wdata} !== 10'h0) $display("FAIL reset_mem_bus: got %h expected 000", {bus0.mem_we, bus0.mem_re, bus0.mem_addr, bus0.mem_wdata}); else passes++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_mats_clean();
        run(2'b00, 4'h0, 1'b0);
        checks++; if (done0_cyc !== 82) $display("FAIL mats_done_cycle: got %0d expected 82", done0_cyc); else passes++;
        checks++; if (ops0 !== 80) $display("FAIL mats_op_count: got %0d expected 80", ops0); else passes++;
        checks++; if ({fail0, fc0} !== 9'h0) $display("FAIL mats_clean_fail: got fail=%b count=%0d expected 0/0", fail0, fc0); else passes++;
        checks++; if (busy0 !== 1'b0) $display("FAIL mats_busy_at_done: got %b expected 0", busy0); else passes++;
    endtask

    task automatic test_marchc_fault();
        stuck[5] = 4'b0001;
        run(2'b01, 4'h0, 1'b0);
        checks++; if (done0_cyc !== 162) $display("FAIL marchc_done_cycle: got %0d expected 162", done0_cyc); else passes++;
        checks++; if (ops0 !== 160) $display("FAIL marchc_op_count: got %0d expected 160", ops0); else passes++;
        checks++; if (fail0 !== 1'b1) $display("FAIL marchc_fail: got %b expected 1", fail0); else passes++;
        checks++; if (fa0 !== 4'd5) $display("FAIL marchc_fail_addr: got %0d expected 5", fa0); else passes++;
        checks++; if (fd0 !== 4'b0001) $display("FAIL marchc_fail_data: got %b expected 0001", fd0); else passes++;
        checks++; if (fc0 !== 8'd3) $display("FAIL marchc_fail_count: got %0d expected 3", fc0); else passes++;
    endtask

    task automatic test_mats_fault();
        run(2'b00, 4'h0, 1'b0);
        checks++; if (done0_cyc !== 82) $display("FAIL mats_fault_done_cycle: got %0d expected 82", done0_cyc); else passes++;
        checks++; if (fc0 !== 8'd1) $display("FAIL mats_fault_count: got %0d expected 1", fc0); else passes++;
        checks++; if (fa0 !== 4'd5) $display("FAIL mats_fault_addr: got %0d expected 5", fa0); else passes++;
    endtask

    task automatic test_bg_inverted();
        run(2'b01, 4'b1111, 1'b0);
        checks++; if (fc0 !== 8'd2) $display("FAIL bg_fail_count: got %0d expected 2", fc0); else passes++;
        checks++; if (fd0 !== 4'b0001) $display("FAIL bg_fail_data: got %b expected 0001", fd0); else passes++;
        checks++; if (fa0 !== 4'd5) $display("FAIL bg_fail_addr: got %0d expected 5", fa0); else passes++;
    endtask

    task automatic test_stop_on_fail();
        run(2'b00, 4'h0, 1'b0);
        checks++; if (ops1 !== 27) $display("FAIL stop_op_count: got %0d expected 27", ops1); else passes++;
        checks++; if (done1_cyc !== 30) $display("FAIL stop_done_cycle: got %0d expected 30", done1_cyc); else passes++;
        checks++; if (fc1 !== 8'd1) $display("FAIL stop_fail_count: got %0d expected 1", fc1); else passes++;
        checks++; if ({fail1, fa1, fd1} !== {1'b1, 4'd5, 4'b0001}) $display("FAIL stop_capture: got %b/%0d/%b expected 1/5/0001", fail1, fa1, fd1); else passes++;
    endtask

    task automatic test_back_to_back();
        stuck[5] = 4'h0;
        run(2'b00, 4'h0, 1'b0);
        checks++; if ({fail0_c1, done0_c1, busy0_c1} !== 3'b001) $display("FAIL b2b_clear_at_start: got %b expected 001", {fail0_c1, done0_c1, busy0_c1}); else passes++;
        checks++; if ({done0_cyc, fail0} !== {32'd82, 1'b0}) $display("FAIL b2b_first_result: got cyc=%0d fail=%b expected 82/0", done0_cyc, fail0); else passes++;
        stuck[5] = 4'b0001;
        run(2'b00, 4'h0, 1'b1);
        checks++; if (fail0_c1 !== 1'b0) $display("FAIL b2b_second_clear: got %b expected 0", fail0_c1); else passes++;
        checks++; if (done0_cyc !== 82) $display("FAIL b2b_glitch_done_cycle: got %0d expected 82", done0_cyc); else passes++;
        checks++; if ({fail0, fa0, fc0} !== {1'b1, 4'd5, 8'd1}) $display("FAIL b2b_second_result: got %b/%0d/%0d expected 1/5/1", fail0, fa0, fc0); else passes++;
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start = 1'b1; mode = 2'b01; bg = 4'h0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        checks++; if ({busy0, fc0} !== {1'b1, 8'd1}) $display("FAIL midrun_pre_reset: got busy=%b count=%0d expected 1/1", busy0, fc0); else passes++;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy0, done0, fail0, fc0, fa0, fd0} !== 19'h0) $display("FAIL midrun_reset_outputs: got %h expected 0", {busy0, done0, fail0, fc0, fa0, fd0}); else passes++;
        checks++; if ({bus0.mem_we, bus0.mem_re} !== 2'b00) $display("FAIL midrun_reset_mem_ops: got %b expected 00", {bus0.mem_we, bus0.mem_re}); else passes++;
        @(negedge clk); rst = 1'b0;
        run(2'b01, 4'h0, 1'b0);
        checks++; if ({done0_cyc, fc0} !== {32'd162, 8'd3}) $display("FAIL midrun_rerun: got cyc=%0d count=%0d expected 162/3", done0_cyc, fc0); else passes++;
    endtask

    task automatic test_invalid_mode();
        run(2'b10, 4'h0, 1'b0);
        checks++; if (done0_cyc !== 1) $display("FAIL invalid_done_cycle: got %0d expected 1", done0_cyc); else passes++;
        checks++; if (ops0 !== 0) $display("FAIL invalid_op_count: got %0d expected 0", ops0); else passes++;
        checks++; if ({fail0, fc0, fa0} !== {1'b1, 8'd0, 4'd0}) $display("FAIL invalid_flags: got %b/%0d/%0d expected 1/0/0", fail0, fc0, fa0); else passes++;
    endtask

    initial begin
        test_reset();
        test_mats_clean();
        test_marchc_fault();
        test_mats_fault();
        test_bg_inverted();
        test_stop_on_fail();
        test_back_to_back();
        test_reset_midrun();
        test_invalid_mode();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
